// File: rtl/wfifo_pkg.sv
// Shared definitions for the SEU-hardened asynchronous FIFO write side.
// Holds pointer geometry, the default data width and the majority voter.
package wfifo_pkg;

    localparam int FIFO_AW = 3;
    localparam int PTR_W   = FIFO_AW + 1;
    localparam int DEF_DW  = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_vote_reg.sv
// Register with async reset; triplicated and majority-voted when
// WFIFO_WR_TMR_EN is defined, otherwise a single flop.
module tmr_vote_reg
    import wfifo_pkg::*;
#(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

`ifdef WFIFO_WR_TMR_EN
    logic [W-1:0] r0_q;
    logic [W-1:0] r1_q;
    logic [W-1:0] r2_q;

    // Every copy reloads from d, which is computed from the voted q, so an
    // upset copy is overwritten at the next edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r0_q <= RST_VAL;
            r1_q <= RST_VAL;
            r2_q <= RST_VAL;
        end else begin
            r0_q <= d;
            r1_q <= d;
            r2_q <= d;
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < W; i++) begin
            q[i] = maj3(r0_q[i], r1_q[i], r2_q[i]);
        end
    end
`else
    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;
`endif

endmodule

// File: rtl/wfifo_wr_ctrl_seu.sv
// Write-side front end of the 8-deep async FIFO: head+skid buffer, write strobe,
// read-pointer synchroniser, overflow counter. TMR enabled by WFIFO_WR_TMR_EN.
module wfifo_wr_ctrl_seu
    import wfifo_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int CW           = 8,
    parameter int DROP_ON_FULL = 0
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    input  logic             wfull,
    input  logic [PTR_W-1:0] rptr,
    output logic [PTR_W-1:0] wq2_rptr,
    output logic             winc,
    output logic [DW-1:0]    wdata,
    output logic [CW-1:0]    ovf_cnt
);

    logic             head_v_d, head_v_q;
    logic [DW-1:0]    head_d_d, head_d_q;
    logic             skid_v_d, skid_v_q;
    logic [DW-1:0]    skid_d_d, skid_d_q;
    logic [PTR_W-1:0] s1_q, s2_q;
    logic [CW-1:0]    ovf_d, ovf_q;
    logic             pop, push;

    tmr_vote_reg #(.W(1))     u_head_v (.wclk(wclk), .wrst_n(wrst_n), .d(head_v_d), .q(head_v_q));
    tmr_vote_reg #(.W(DW))    u_head_d (.wclk(wclk), .wrst_n(wrst_n), .d(head_d_d), .q(head_d_q));
    tmr_vote_reg #(.W(1))     u_skid_v (.wclk(wclk), .wrst_n(wrst_n), .d(skid_v_d), .q(skid_v_q));
    tmr_vote_reg #(.W(DW))    u_skid_d (.wclk(wclk), .wrst_n(wrst_n), .d(skid_d_d), .q(skid_d_q));
    tmr_vote_reg #(.W(CW))    u_ovf    (.wclk(wclk), .wrst_n(wrst_n), .d(ovf_d),    .q(ovf_q));

    // Two-stage synchroniser: stages are wired back to back, nothing in between.
    tmr_vote_reg #(.W(PTR_W)) u_s1     (.wclk(wclk), .wrst_n(wrst_n), .d(rptr),     .q(s1_q));
    tmr_vote_reg #(.W(PTR_W)) u_s2     (.wclk(wclk), .wrst_n(wrst_n), .d(s1_q),     .q(s2_q));

    assign in_ready = (DROP_ON_FULL != 0) ? 1'b1 : ~skid_v_q;
    assign winc     = head_v_q & ~wfull;
    assign wdata    = head_d_q;
    assign wq2_rptr = s2_q;
    assign ovf_cnt  = ovf_q;
    assign pop      = winc;
    assign push     = in_valid & in_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        head_v_d = head_v_q;
        head_d_d = head_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        ovf_d    = ovf_q;

        unique case ({head_v_q, skid_v_q})
            2'b00: begin
                if (push) begin
                    head_v_d = 1'b1;
                    head_d_d = in_data;
                end
            end
            2'b10: begin
                if (pop && push) begin
                    head_d_d = in_data;
                end else if (pop) begin
                    head_v_d = 1'b0;
                end else if (push) begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end
            end
            2'b11: begin
                if (pop) begin
                    head_d_d = skid_d_q;
                    if (push) begin
                        skid_d_d = in_data;
                    end else begin
                        skid_v_d = 1'b0;
                    end
                end else if (push) begin
                    // Only reachable in drop mode: the word is lost and counted.
                    if (ovf_q != {CW{1'b1}}) begin
                        ovf_d = ovf_q + CW'(1);
                    end
                end
            end
            default: begin
                // Skid without head is unreachable; promote the skid to stay ordered.
                head_v_d = 1'b1;
                head_d_d = skid_d_q;
                skid_v_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wfifo_wr_ctrl_seu.sv
// Directed bench for wfifo_wr_ctrl_seu: a backpressure instance and a
// drop-mode instance (CW=2) share clock, reset and rptr.
module tb_wfifo_wr_ctrl_seu;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic [3:0]  rptr = '0;

    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        wfull = 1'b0;
    logic [3:0]  wq2_rptr;
    logic        winc;
    logic [15:0] wdata;
    logic [7:0]  ovf_cnt;

    logic        d_in_valid = 1'b0;
    logic [15:0] d_in_data = '0;
    logic        d_in_ready;
    logic        d_wfull = 1'b0;
    logic [3:0]  d_wq2_rptr;
    logic        d_winc;
    logic [15:0] d_wdata;
    logic [1:0]  d_ovf_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 wclk = ~wclk;

    wfifo_wr_ctrl_seu #(.DW(16), .CW(8), .DROP_ON_FULL(0)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wfull(wfull), .rptr(rptr), .wq2_rptr(wq2_rptr),
        .winc(winc), .wdata(wdata), .ovf_cnt(ovf_cnt)
    );

    wfifo_wr_ctrl_seu #(.DW(16), .CW(2), .DROP_ON_FULL(1)) dut_drop (
        .wclk(wclk), .wrst_n(wrst_n), .in_valid(d_in_valid), .in_data(d_in_data),
        .in_ready(d_in_ready), .wfull(d_wfull), .rptr(rptr), .wq2_rptr(d_wq2_rptr),
        .winc(d_winc), .wdata(d_wdata), .ovf_cnt(d_ovf_cnt)
    );

    // Inputs change just after the falling edge; outputs are read 1 ns later.
    task automatic next_cycle();
        @(negedge wclk);
    endtask

    task automatic test_reset();
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        chk_cnt++; if (winc !== 1'b0) $display("FAIL reset_winc got=%b exp=0", winc); else pass_cnt++;
        chk_cnt++; if (wdata !== 16'h0) $display("FAIL reset_wdata got=%h exp=0000", wdata); else pass_cnt++;
        chk_cnt++; if (wq2_rptr !== 4'h0) $display("FAIL reset_wq2_rptr got=%h exp=0", wq2_rptr); else pass_cnt++;
        chk_cnt++; if (ovf_cnt !== 8'h0) $display("FAIL reset_ovf got=%h exp=00", ovf_cnt); else pass_cnt++;
        chk_cnt++; if (d_ovf_cnt !== 2'h0) $display("FAIL reset_d_ovf got=%h exp=0", d_ovf_cnt); else pass_cnt++;
        next_cycle();
        wrst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic        exp_winc;
        logic [15:0] exp_data;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            in_valid = (i < 8);
            in_data  = 16'(i + 1);
            #1;
            exp_winc = (i >= 1) && (i <= 8);
            exp_data = 16'(i);
            chk_cnt++;
            if (winc !== exp_winc) $display("FAIL stream_winc cyc=%0d got=%b exp=%b", i, winc, exp_winc);
            else pass_cnt++;
            if (exp_winc) begin
                chk_cnt++;
                if (wdata !== exp_data) $display("FAIL stream_wdata cyc=%0d got=%h exp=%h", i, wdata, exp_data);
                else pass_cnt++;
            end
            chk_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, in_ready);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        // Per cycle: wfull, in_valid, in_data, expected in_ready, winc, wdata.
        logic        t_full [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic        t_vld  [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic [15:0] t_dat  [7] = '{16'hA1, 16'hA2, 16'hA3, 16'hA3, 16'hA3, 16'h0, 16'h0};
        logic        e_rdy  [7] = '{1, 1, 0, 0, 1, 1, 1};
        logic        e_winc [7] = '{0, 0, 0, 1, 1, 1, 0};
        logic [15:0] e_dat  [7] = '{16'h0, 16'h0, 16'h0, 16'hA1, 16'hA2, 16'hA3, 16'h0};
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            wfull    = t_full[i];
            in_valid = t_vld[i];
            in_data  = t_dat[i];
            #1;
            chk_cnt++;
            if (in_ready !== e_rdy[i]) $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, in_ready, e_rdy[i]);
            else pass_cnt++;
            chk_cnt++;
            if (winc !== e_winc[i]) $display("FAIL bp_winc cyc=%0d got=%b exp=%b", i, winc, e_winc[i]);
            else pass_cnt++;
            if (e_winc[i]) begin
                chk_cnt++;
                if (wdata !== e_dat[i]) $display("FAIL bp_wdata cyc=%0d got=%h exp=%h", i, wdata, e_dat[i]);
                else pass_cnt++;
            end
        end
        chk_cnt++; if (ovf_cnt !== 8'h0) $display("FAIL bp_ovf got=%h exp=00", ovf_cnt); else pass_cnt++;
    endtask

    task automatic test_drop();
        // Six words offered against a full FIFO: B1,B2 kept, four dropped, counter saturates at 3.
        logic [1:0] e_ovf [6] = '{0, 0, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            d_wfull    = 1'b1;
            d_in_valid = 1'b1;
            d_in_data  = 16'hB1 + 16'(i);
            #1;
            chk_cnt++;
            if (d_in_ready !== 1'b1) $display("FAIL drop_ready cyc=%0d got=%b exp=1", i, d_in_ready);
            else pass_cnt++;
            chk_cnt++;
            if (d_ovf_cnt !== e_ovf[i]) $display("FAIL drop_ovf cyc=%0d got=%0d exp=%0d", i, d_ovf_cnt, e_ovf[i]);
            else pass_cnt++;
            chk_cnt++;
            if (d_winc !== 1'b0) $display("FAIL drop_winc_full cyc=%0d got=%b exp=0", i, d_winc);
            else pass_cnt++;
        end
        next_cycle();
        d_in_valid = 1'b0;
        d_wfull    = 1'b0;
        #1;
        chk_cnt++; if (d_ovf_cnt !== 2'd3) $display("FAIL drop_ovf_sat got=%0d exp=3", d_ovf_cnt); else pass_cnt++;
        chk_cnt++; if (d_winc !== 1'b1 || d_wdata !== 16'hB1) $display("FAIL drop_wr0 got=%b/%h exp=1/00b1", d_winc, d_wdata); else pass_cnt++;
        next_cycle();
        #1;
        chk_cnt++; if (d_winc !== 1'b1 || d_wdata !== 16'hB2) $display("FAIL drop_wr1 got=%b/%h exp=1/00b2", d_winc, d_wdata); else pass_cnt++;
        next_cycle();
        #1;
        chk_cnt++; if (d_winc !== 1'b0) $display("FAIL drop_wr_end got=%b exp=0", d_winc); else pass_cnt++;
        chk_cnt++; if (d_ovf_cnt !== 2'd3) $display("FAIL drop_ovf_hold got=%0d exp=3", d_ovf_cnt); else pass_cnt++;
    endtask

    task automatic test_sync();
        // rptr value driven in each cycle and wq2_rptr expected in that cycle.
        logic [3:0] t_rptr [6] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h3};
        logic [3:0] e_q2   [6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3};
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #3;
            rptr = t_rptr[i];
            #1;
            chk_cnt++;
            if (wq2_rptr !== e_q2[i]) $display("FAIL sync cyc=%0d got=%h exp=%h", i, wq2_rptr, e_q2[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop();
        next_cycle();
        wfull = 1'b1; in_valid = 1'b1; in_data = 16'hC1;
        next_cycle();
        in_data = 16'hC2;
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL midrst_full got=%b exp=0", in_ready); else pass_cnt++;
        #1;
        wfull  = 1'b0;
        wrst_n = 1'b0;
        #1;
        chk_cnt++; if (winc !== 1'b0) $display("FAIL midrst_winc got=%b exp=0", winc); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", in_ready); else pass_cnt++;
        chk_cnt++; if (d_ovf_cnt !== 2'd0) $display("FAIL midrst_ovf got=%0d exp=0", d_ovf_cnt); else pass_cnt++;
        next_cycle();
        wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk_cnt++;
            if (winc !== 1'b0) $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, winc);
            else pass_cnt++;
        end
    endtask

`ifdef WFIFO_WR_TMR_EN
    task automatic test_tmr_upset();
        logic [15:0] bad;
        next_cycle();
        wfull = 1'b1; in_valid = 1'b1; in_data = 16'hD5A5;
        next_cycle();
        in_valid = 1'b0;
        bad = 16'hD5AD;
        force dut.u_head_d.r1_q = bad;
        #1;
        chk_cnt++; if (wdata !== 16'hD5A5) $display("FAIL tmr_vote got=%h exp=d5a5", wdata); else pass_cnt++;
        release dut.u_head_d.r1_q;
        next_cycle();
        #1;
        chk_cnt++; if (dut.u_head_d.r1_q !== 16'hD5A5) $display("FAIL tmr_realign got=%h exp=d5a5", dut.u_head_d.r1_q); else pass_cnt++;
        chk_cnt++; if (wdata !== 16'hD5A5) $display("FAIL tmr_wdata got=%h exp=d5a5", wdata); else pass_cnt++;
        wfull = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_sync();
        test_reset_midop();
`ifdef WFIFO_WR_TMR_EN
        test_tmr_upset();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
